instruction_fetch_unit: RTL



---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_skid_buffer.sv | 66 ++++++
 rtl/instruction_fetch_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its output buffer.
package fetch_pkg;

  localparam int unsigned WORD_W        = 64;
  localparam int unsigned ADDR_W        = 64;
  localparam int unsigned DEF_MEM_DEPTH = 1024;
  localparam int unsigned DEF_BUF_DEPTH = 2;
  localparam logic [ADDR_W-1:0] DEF_RESET_PC = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO of {pc, instr} between the memory response and decode.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output logic         valid_o,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    // A flush drops everything, including a response arriving in the same cycle.
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) ent0_d = data_i;
          else                 ent1_d = data_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          ent0_d  = ent1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            ent0_d = ent1_q;
            ent1_d = data_i;
          end else begin
            ent0_d = data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign head_o  = ent0_q;
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC owner and read initiator for the 64-bit instruction memory; feeds decode via valid/ready.
// state | meaning: IDLE | no fetch; RUN | issuing reads; DRAIN | no issue, waiting for buffer/in-flight to empty
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = DEF_RESET_PC,
  parameter int unsigned       MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int unsigned       BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stop,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic              MemE,
  output logic              MemRW,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [WORD_W-1:0] MemDataIn,
  input  logic [WORD_W-1:0] MemDataOut,
  output logic              InstrValid,
  input  logic              InstrReady,
  output logic [WORD_W-1:0] Instr,
  output logic [ADDR_W-1:0] InstrPC,
  output logic              Busy
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_DEPTH - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, tag_pc_q, tag_pc_d;
  logic              inflight_q, inflight_d, squash_q, squash_d;

  logic [1:0]   count;
  logic         buf_valid;
  fetch_entry_t head;
  fetch_entry_t resp;
  logic         pop, push, flush, issue;
  logic [2:0]   occupancy;

  assign pop   = buf_valid & InstrReady;
  assign flush = BranchTaken & (state_q != ST_IDLE);
  assign push  = inflight_q & ~squash_q;
  assign resp  = '{pc: tag_pc_q, instr: MemDataOut};

  // Reserve a buffer slot for every read in flight so a response can never overflow.
  assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == ST_RUN) & ~Stop & ~BranchTaken & (occupancy < 3'(BUF_DEPTH));

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tag_pc_d   = tag_pc_q;
    inflight_d = issue;
    squash_d   = flush & inflight_q;
    if (issue) begin
      tag_pc_d = pc_q;
      pc_d     = (pc_q == LAST_PC) ? '0 : pc_q + 1'b1;
    end
    if (BranchTaken) pc_d = BranchTarget;
    unique case (state_q)
      ST_IDLE:  if (Start && !Stop) state_d = ST_RUN;
      ST_RUN:   if (Stop) state_d = ST_DRAIN;
      ST_DRAIN: if (!inflight_q && (flush || count == {1'b0, pop})) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      tag_pc_q   <= '0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tag_pc_q   <= tag_pc_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
    end
  end

  fetch_skid_buffer u_buf (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (resp),
    .valid_o (buf_valid),
    .head_o  (head),
    .count_o (count)
  );

  assign MemE       = issue & ~Reset;
  assign MemRW      = 1'b1;
  assign MemAddress = pc_q;
  assign MemDataIn  = '0;
  assign InstrValid = buf_valid;
  assign Instr      = head.instr;
  assign InstrPC    = head.pc;
  assign Busy       = (state_q != ST_IDLE);

endmodule
